// File: rtl/sram_req_ctrl.sv
// In-order request sequencer for the 8x32 dual-port SRAM: valid/ready command FIFO in,
// registered SRAM strobes out, read data returned on a valid/ready response port.
module sram_req_ctrl #(
  parameter int DW         = 32,
  parameter int AW         = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] rsp_addr,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(RD_LAT + 2);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RSP} state_t;

  req_t [FIFO_DEPTH-1:0] fifo_q;
  req_t                  head;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q;
  logic                  push, pop;

  state_t        state_q, state_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic          wr_d, rd_d, rv_d;
  logic [AW-1:0] addr_d, raddr_d;
  logic [DW-1:0] din_d, rdata_d;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
  assign req_ready = (count_q != CW'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign head      = fifo_q[rptr_q];
  assign busy      = (count_q != '0) || (state_q != IDLE) || mem_wr || mem_rd;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {req_we, req_addr, req_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pop     = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = mem_addr;
    din_d   = mem_din;
    rv_d    = rsp_valid;
    rdata_d = rsp_rdata;
    raddr_d = rsp_addr;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop    = 1'b1;
          addr_d = head.addr;
          if (head.we) begin
            wr_d  = 1'b1;
            din_d = head.wdata;
          end else begin
            rd_d    = 1'b1;
            wcnt_d  = LW'(RD_LAT);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // mem_addr is not touched while a read is outstanding, so it still names the read.
        if (wcnt_q == '0) begin
          rv_d    = 1'b1;
          rdata_d = mem_dout;
          raddr_d = mem_addr;
          state_d = RSP;
        end else begin
          wcnt_d = wcnt_q - LW'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_wr    <= wr_d;
      mem_rd    <= rd_d;
      mem_addr  <= addr_d;
      mem_din   <= din_d;
      rsp_valid <= rv_d;
      rsp_rdata <= rdata_d;
      rsp_addr  <= raddr_d;
    end
  end
endmodule
